// File: rtl/hb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// hb_sram_slave_if
// Bundle of the HB request fields one device slot sees from the HB
// controller, together with the responses the slot returns.
//   ren / wen      : this slot's read / write selects
//   raddr / waddr  : byte addresses of the read / write request
//   wdata          : write data (lane placement is done by the responder)
//   write_width    : 0 = byte, 1 = halfword, 2/3 = word
//   rdata          : read data returned to the controller
//   read_finish    : one-cycle read completion pulse
//   write_finish   : one-cycle write completion pulse
// ---------------------------------------------------------------------------
interface hb_sram_slave_if;
  logic        ren;
  logic        wen;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [1:0]  write_width;
  logic [31:0] rdata;
  logic        read_finish;
  logic        write_finish;

  modport master (
    output ren, wen, raddr, waddr, wdata, write_width,
    input  rdata, read_finish, write_finish
  );

  modport slave (
    input  ren, wen, raddr, waddr, wdata, write_width,
    output rdata, read_finish, write_finish
  );
endinterface

// File: rtl/hb_sram_slave.sv
// ---------------------------------------------------------------------------
// hb_sram_slave
// HB responder that bridges one device slot onto a single-port synchronous
// SRAM. Handles read latency, write wait states, byte/halfword lane writes
// and alternating service when a read and a write arrive together.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : HB request/response bundle (slave modport)
//   mem_ce       : SRAM access strobe
//   mem_we       : SRAM write strobe
//   mem_addr     : SRAM word address
//   mem_be       : SRAM byte enables
//   mem_wdata    : SRAM write data
//   mem_rdata    : SRAM read data, valid RD_LATENCY cycles after mem_ce
// ---------------------------------------------------------------------------
module hb_sram_slave #(
  parameter int DEPTH      = 1024,
  parameter int MEM_AW     = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int WR_WAIT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  hb_sram_slave_if.slave    bus,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [2:0] RD_LAT_C  = 3'(RD_LATENCY);
  localparam logic [2:0] WR_WAIT_C = 3'(WR_WAIT);

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [31:0] hold, hold_next;
  logic        last_wr, last_wr_next;
  logic        rd_oor, rd_oor_next;

  logic [MEM_AW-1:0] raddr_idx, waddr_idx;
  logic              raddr_oor, waddr_oor;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              pick_write;
  logic              commit, rd_start, rd_fin;
  logic [31:0]       rd_value;
  logic              unused_addr_bits;

  assign raddr_idx = bus.raddr[MEM_AW+1:2];
  assign waddr_idx = bus.waddr[MEM_AW+1:2];

  // Device selection already happened upstream, so upper address bits are
  // don't-care here.
  assign unused_addr_bits = ^{bus.raddr[31:MEM_AW+2], bus.raddr[1:0],
                              bus.waddr[31:MEM_AW+2]};

  // Out-of-range words exist only when the address field is wider than the
  // physical array.
  if ((1 << MEM_AW) > DEPTH) begin : g_oor
    assign raddr_oor = raddr_idx >= MEM_AW'(DEPTH);
    assign waddr_oor = waddr_idx >= MEM_AW'(DEPTH);
  end else begin : g_no_oor
    assign raddr_oor = 1'b0;
    assign waddr_oor = 1'b0;
  end

  // Lane placement: narrow writes are replicated across the word so the
  // byte enables alone pick the target lanes.
  always_comb begin
    wr_be   = 4'hF;
    wr_data = bus.wdata;
    case (bus.write_width)
      2'd0: begin
        wr_be   = 4'b0001 << bus.waddr[1:0];
        wr_data = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = bus.waddr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // On a tie, serve the kind that did not finish most recently.
  assign pick_write = bus.wen && (!bus.ren || !last_wr);

  assign rd_value = rd_oor ? 32'h0 : mem_rdata;

  // Next-state logic. Nothing starts while reset is held, which keeps every
  // output at zero even if selects are asserted during reset.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hold_next    = hold;
    last_wr_next = last_wr;
    rd_oor_next  = rd_oor;
    commit       = 1'b0;
    rd_start     = 1'b0;
    rd_fin       = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (pick_write) begin
            if (WR_WAIT == 0) begin
              commit = 1'b1;
            end else begin
              cnt_next   = 3'd1;
              state_next = WRITE;
            end
          end else if (bus.ren) begin
            rd_start    = 1'b1;
            rd_oor_next = raddr_oor;
            cnt_next    = 3'd1;
            state_next  = READ;
          end
        end
        READ: begin
          if (!bus.ren) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end else if (cnt == RD_LAT_C) begin
            rd_fin       = 1'b1;
            hold_next    = rd_value;
            last_wr_next = 1'b0;
            state_next   = IDLE;
            cnt_next     = 3'd0;
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
        WRITE: begin
          if (!bus.wen) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end else if (cnt == WR_WAIT_C) begin
            commit     = 1'b1;
            state_next = IDLE;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (commit) last_wr_next = 1'b1;
    end
  end

  // SRAM strobes: a write commit uses the live bus fields; a read only
  // strobes in its first cycle. Out-of-range accesses leave the SRAM idle.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    if (commit && !waddr_oor) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = waddr_idx;
      mem_be    = wr_be;
      mem_wdata = wr_data;
    end else if (rd_start && !raddr_oor) begin
      mem_ce   = 1'b1;
      mem_addr = raddr_idx;
    end
  end

  assign bus.rdata        = rd_fin ? rd_value : hold;
  assign bus.read_finish  = rd_fin;
  assign bus.write_finish = commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      hold    <= 32'h0;
      last_wr <= 1'b0;
      rd_oor  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hold    <= hold_next;
      last_wr <= last_wr_next;
      rd_oor  <= rd_oor_next;
    end
  end

endmodule

// File: tb/tb_hb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_hb_sram_slave
// Two responder instances, each with a behavioural SRAM:
//   dut_a : DEPTH=16, MEM_AW=5 (wider than the array), RD_LATENCY=1, WR_WAIT=0
//   dut_b : DEPTH=16, MEM_AW=4, RD_LATENCY=3, WR_WAIT=2
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_hb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  hb_sram_slave_if bus_a();
  hb_sram_slave_if bus_b();

  logic        mem_ce_a, mem_we_a;
  logic [4:0]  mem_addr_a;
  logic [3:0]  mem_be_a;
  logic [31:0] mem_wdata_a, mem_rdata_a;

  logic        mem_ce_b, mem_we_b;
  logic [3:0]  mem_addr_b;
  logic [3:0]  mem_be_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;

  hb_sram_slave #(.DEPTH(16), .MEM_AW(5), .RD_LATENCY(1), .WR_WAIT(0)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a),
    .mem_ce(mem_ce_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_be(mem_be_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  hb_sram_slave #(.DEPTH(16), .MEM_AW(4), .RD_LATENCY(3), .WR_WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b),
    .mem_ce(mem_ce_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_be(mem_be_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    merge_bytes = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  // Behavioural SRAMs; a cycle with no read loads a poison value so a
  // finish landing in the wrong cycle shows up as bad data.
  logic [31:0] ram_a [0:31];
  logic [31:0] pipe_a;
  always @(posedge clk) begin
    if (mem_ce_a && mem_we_a)
      ram_a[mem_addr_a] <= merge_bytes(ram_a[mem_addr_a], mem_wdata_a, mem_be_a);
    pipe_a <= (mem_ce_a && !mem_we_a) ? ram_a[mem_addr_a] : 32'hBAD0BAD0;
  end
  assign mem_rdata_a = pipe_a;

  logic [31:0] ram_b [0:15];
  logic [31:0] pipe_b [0:2];
  always @(posedge clk) begin
    if (mem_ce_b && mem_we_b)
      ram_b[mem_addr_b] <= merge_bytes(ram_b[mem_addr_b], mem_wdata_b, mem_be_b);
    pipe_b[0] <= (mem_ce_b && !mem_we_b) ? ram_b[mem_addr_b] : 32'hBAD0BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_rdata_b = pipe_b[2];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
    logic        exp_ce;
    logic [4:0]  exp_ma;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [17];

  // One complete access on dut_a, starting and ending at a drive point.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_write) begin
      bus_a.wen         = 1'b1;
      bus_a.waddr       = v.addr;
      bus_a.wdata       = v.data;
      bus_a.write_width = v.width;
      @(negedge clk);
      checkOutput({tag, "_wfin"},  32'(bus_a.write_finish), 32'd1);
      checkOutput({tag, "_ce"},    32'(mem_ce_a), 32'(v.exp_ce));
      checkOutput({tag, "_we"},    32'(mem_we_a), 32'(v.exp_ce));
      checkOutput({tag, "_addr"},  32'(mem_addr_a), 32'(v.exp_ma));
      checkOutput({tag, "_be"},    32'(mem_be_a), 32'(v.exp_be));
      checkOutput({tag, "_wdata"}, mem_wdata_a, v.exp_wd);
      next_cycle();
      bus_a.wen = 1'b0;
    end else begin
      bus_a.ren   = 1'b1;
      bus_a.raddr = v.addr;
      @(negedge clk);
      checkOutput({tag, "_ce"},   32'(mem_ce_a), 32'(v.exp_ce));
      checkOutput({tag, "_addr"}, 32'(mem_addr_a), 32'(v.exp_ma));
      checkOutput({tag, "_rfin0"}, 32'(bus_a.read_finish), 32'd0);
      next_cycle();
      @(negedge clk);
      checkOutput({tag, "_rfin1"}, 32'(bus_a.read_finish), 32'd1);
      checkOutput({tag, "_rdata"}, bus_a.rdata, v.exp_rd);
      next_cycle();
      bus_a.ren = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_rfin2"}, 32'(bus_a.read_finish), 32'd0);
      checkOutput({tag, "_hold"},  bus_a.rdata, v.exp_rd);
      next_cycle();
    end
  endtask

  // Read on dut_b: finish exactly three cycles after the request.
  task automatic b_read(input logic [31:0] addr, input logic [31:0] exp_rd,
                        input string tag);
    bus_b.ren   = 1'b1;
    bus_b.raddr = addr;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_rfin_c%0d", tag, c), 32'(bus_b.read_finish),
                  (c == 3) ? 32'd1 : 32'd0);
      if (c == 0) checkOutput({tag, "_ce"}, 32'(mem_ce_b), 32'd1);
      if (c == 3) checkOutput({tag, "_rdata"}, bus_b.rdata, exp_rd);
      next_cycle();
    end
    bus_b.ren = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_rfin_after"}, 32'(bus_b.read_finish), 32'd0);
    checkOutput({tag, "_hold"}, bus_b.rdata, exp_rd);
    next_cycle();
  endtask

  logic [15:0] order;
  int          n_seen;

  initial begin
    //            wr    addr        data          w     ce    ma     be       wdata         rdata
    vecs[0]  = '{1'b1, 32'h14, 32'hDEADBEEF, 2'd2, 1'b1, 5'd5, 4'hF,    32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h14, 32'h0,        2'd0, 1'b1, 5'd5, 4'h0,    32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h18, 32'h11223344, 2'd2, 1'b1, 5'd6, 4'hF,    32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 32'h1A, 32'h000000AA, 2'd0, 1'b1, 5'd6, 4'b0100, 32'hAAAAAAAA, 32'h0};
    vecs[4]  = '{1'b0, 32'h18, 32'h0,        2'd0, 1'b1, 5'd6, 4'h0,    32'h0,        32'h11AA3344};
    vecs[5]  = '{1'b1, 32'h18, 32'h00005566, 2'd1, 1'b1, 5'd6, 4'b0011, 32'h55665566, 32'h0};
    vecs[6]  = '{1'b0, 32'h18, 32'h0,        2'd0, 1'b1, 5'd6, 4'h0,    32'h0,        32'h11AA5566};
    vecs[7]  = '{1'b1, 32'h1B, 32'hCAFE9988, 2'd1, 1'b1, 5'd6, 4'b1100, 32'h99889988, 32'h0};
    vecs[8]  = '{1'b0, 32'h18, 32'h0,        2'd0, 1'b1, 5'd6, 4'h0,    32'h0,        32'h99885566};
    vecs[9]  = '{1'b1, 32'h1C, 32'h01020304, 2'd2, 1'b1, 5'd7, 4'hF,    32'h01020304, 32'h0};
    vecs[10] = '{1'b1, 32'h1F, 32'h0000005A, 2'd0, 1'b1, 5'd7, 4'b1000, 32'h5A5A5A5A, 32'h0};
    vecs[11] = '{1'b0, 32'h1C, 32'h0,        2'd0, 1'b1, 5'd7, 4'h0,    32'h0,        32'h5A020304};
    vecs[12] = '{1'b1, 32'h40, 32'h12345678, 2'd3, 1'b0, 5'd0, 4'h0,    32'h0,        32'h0};
    vecs[13] = '{1'b0, 32'h40, 32'h0,        2'd0, 1'b0, 5'd0, 4'h0,    32'h0,        32'h0};
    vecs[14] = '{1'b0, 32'h94, 32'h0,        2'd0, 1'b1, 5'd5, 4'h0,    32'h0,        32'hDEADBEEF};
    vecs[15] = '{1'b1, 32'h20, 32'hA5A5F00F, 2'd3, 1'b1, 5'd8, 4'hF,    32'hA5A5F00F, 32'h0};
    vecs[16] = '{1'b0, 32'h20, 32'h0,        2'd0, 1'b1, 5'd8, 4'h0,    32'h0,        32'hA5A5F00F};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.ren = 1'b0; bus_a.wen = 1'b0; bus_a.raddr = '0; bus_a.waddr = '0;
    bus_a.wdata = '0; bus_a.write_width = 2'd0;
    bus_b.ren = 1'b0; bus_b.wen = 1'b0; bus_b.raddr = '0; bus_b.waddr = '0;
    bus_b.wdata = '0; bus_b.write_width = 2'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_a_rdata", bus_a.rdata, 32'h0);
    checkOutput("rst_a_rfin",  32'(bus_a.read_finish), 32'd0);
    checkOutput("rst_a_wfin",  32'(bus_a.write_finish), 32'd0);
    checkOutput("rst_b_rdata", bus_b.rdata, 32'h0);
    checkOutput("rst_b_ce",    32'(mem_ce_b), 32'd0);
    next_cycle();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    $display("[TB] dut_a vector table");
    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);

    // Read and write both held from reset: service must alternate,
    // starting with the write.
    $display("[TB] dut_a simultaneous read/write");
    rst_a_n = 1'b0;
    bus_a.ren = 1'b1; bus_a.raddr = 32'h14;
    bus_a.wen = 1'b1; bus_a.waddr = 32'h20; bus_a.wdata = 32'hA5A5F00F;
    bus_a.write_width = 2'd2;
    #1;
    checkOutput("tie_rst_ce",    32'(mem_ce_a), 32'd0);
    checkOutput("tie_rst_we",    32'(mem_we_a), 32'd0);
    checkOutput("tie_rst_wfin",  32'(bus_a.write_finish), 32'd0);
    checkOutput("tie_rst_rdata", bus_a.rdata, 32'h0);
    next_cycle();
    rst_a_n = 1'b1;
    order  = '0;
    n_seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checkOutput($sformatf("tie_both_c%0d", c),
                  32'(bus_a.read_finish && bus_a.write_finish), 32'd0);
      if (bus_a.read_finish && n_seen < 16)
        checkOutput($sformatf("tie_rdata_c%0d", c), bus_a.rdata, 32'hDEADBEEF);
      if ((bus_a.write_finish || bus_a.read_finish) && n_seen < 16) begin
        order[n_seen] = bus_a.write_finish;
        n_seen++;
      end
      next_cycle();
    end
    bus_a.ren = 1'b0;
    bus_a.wen = 1'b0;
    checkOutput("tie_count_ge8", 32'(n_seen >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("tie_order_%0d", i), 32'(order[i]),
                  (i % 2 == 0) ? 32'd1 : 32'd0);

    // dut_b: write with two wait states, finish in cycle 2.
    $display("[TB] dut_b wait states");
    bus_b.wen = 1'b1; bus_b.waddr = 32'h08; bus_b.wdata = 32'h12345678;
    bus_b.write_width = 2'd2;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("b_wr_wfin_c%0d", c), 32'(bus_b.write_finish),
                  (c == 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b_wr_we_c%0d", c), 32'(mem_we_b),
                  (c == 2) ? 32'd1 : 32'd0);
      if (c == 2) begin
        checkOutput("b_wr_addr",  32'(mem_addr_b), 32'd2);
        checkOutput("b_wr_be",    32'(mem_be_b), 32'hF);
        checkOutput("b_wr_wdata", mem_wdata_b, 32'h12345678);
      end
      next_cycle();
    end
    bus_b.wen = 1'b0;
    @(negedge clk);
    checkOutput("b_wr_wfin_after", 32'(bus_b.write_finish), 32'd0);
    next_cycle();

    b_read(32'h08, 32'h12345678, "b_rd");

    // Write select dropped in cycle 1: no commit, memory untouched.
    $display("[TB] dut_b write abort");
    bus_b.wen = 1'b1; bus_b.waddr = 32'h08; bus_b.wdata = 32'hFFFFFFFF;
    bus_b.write_width = 2'd2;
    @(negedge clk);
    checkOutput("b_ab_we_c0", 32'(mem_we_b), 32'd0);
    next_cycle();
    bus_b.wen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("b_ab_we_c%0d", c), 32'(mem_we_b), 32'd0);
      checkOutput($sformatf("b_ab_wfin_c%0d", c), 32'(bus_b.write_finish), 32'd0);
      next_cycle();
    end
    b_read(32'h08, 32'h12345678, "b_ab_rd");

    // Reset while the read is in flight.
    $display("[TB] dut_b reset during read");
    bus_b.ren = 1'b1; bus_b.raddr = 32'h08;
    @(negedge clk);
    checkOutput("b_rr_ce_c0",   32'(mem_ce_b), 32'd1);
    checkOutput("b_rr_hold_c0", bus_b.rdata, 32'h12345678);
    next_cycle();
    rst_b_n = 1'b0;
    #1;
    checkOutput("b_rr_rfin",  32'(bus_b.read_finish), 32'd0);
    checkOutput("b_rr_wfin",  32'(bus_b.write_finish), 32'd0);
    checkOutput("b_rr_ce",    32'(mem_ce_b), 32'd0);
    checkOutput("b_rr_rdata", bus_b.rdata, 32'h0);
    next_cycle();
    bus_b.ren = 1'b0;
    next_cycle();
    rst_b_n = 1'b1;
    @(negedge clk);
    checkOutput("b_rr_rfin_rel", 32'(bus_b.read_finish), 32'd0);
    next_cycle();
    b_read(32'h08, 32'h12345678, "b_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hb_sram_slave.md
# hb_sram_slave

Responder end of the high-speed bus (HB). It accepts the per-device `ren`/`wen` selects and the shared HB request fields produced by the HB controller, and bridges them onto a single-port synchronous SRAM macro. It returns read data and one-cycle `read_finish`/`write_finish` handshakes. It handles wait states, byte-lane writes, and fair ordering when the full-duplex bus presents a read and a write in the same cycle. One instance sits on each HB device slot that holds on-chip RAM.

## Interface
- `DEPTH`, 1024: SRAM size in 32-bit words; power of two, at least 2.
- `MEM_AW`, `$clog2(DEPTH)`: SRAM word-address width.
- `RD_LATENCY`, 1: cycles from SRAM `mem_ce` (read) to valid `mem_rdata`; range 1..7.
- `WR_WAIT`, 0: extra wait cycles before a write commits; range 0..7.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `device_sel`  in  `sel_t`  this slot's `.ren`/`.wen` from the HB controller.
- `bus`  in  `hb_slave_t`  shared `raddr`, `waddr`, `wdata`, `write_width`.
- `rdata`  out  32  read data to the controller's device-data input.
- `read_finish`  out  1  read completes this cycle.
- `write_finish`  out  1  write completes this cycle.
- `mem_ce`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write strobe.
- `mem_addr`  out  `MEM_AW`  SRAM word address.
- `mem_be`  out  4  SRAM byte enables.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data.

## Operation
- Word index is `addr[MEM_AW+1:2]`. Address bits at and above `MEM_AW+2` are ignored; device selection is already done by the controller.
- An access is out of range when the word index is `DEPTH` or greater; this only arises if `MEM_AW` is wider than the real array. Out-of-range writes are dropped (`mem_ce`=0) but still finish. Out-of-range reads return 0 and still finish.
- `write_width` encoding: 0 = byte, 1 = halfword, 2 = word, 3 = word.
  - Byte: `mem_be = 1<<addr[1:0]`, `mem_wdata` = `wdata[7:0]` replicated ×4.
  - Halfword: `mem_be` = 4'b0011 or 4'b1100 selected by `addr[1]`; `addr[0]` ignored; `mem_wdata` = `wdata[15:0]` ×2.
  - Word: `mem_be`=4'hF, `mem_wdata=wdata`.
- Reads always return the full word; the master extracts lanes.
- State machine `IDLE`/`READ`/`WRITE` with a 3-bit wait counter `cnt`.
  - `IDLE`, read chosen: drive `mem_ce`=1, `mem_we`=0, `mem_addr`=raddr word; `cnt`←1; go to `READ`.
  - `READ`: when `cnt==RD_LATENCY`, assert `read_finish`, drive `rdata=mem_rdata`, capture it into the hold register, and go to `IDLE`; otherwise `cnt`++.
  - `IDLE`, write chosen, `WR_WAIT`=0: commit in the same cycle (`mem_ce`=`mem_we`=1, `write_finish`=1) and stay in `IDLE`.
  - `IDLE`, write chosen, `WR_WAIT`>0: `cnt`←1; go to `WRITE`.
  - `WRITE`: at `cnt==WR_WAIT`, commit as above using the live bus fields, then go to `IDLE`.
- Tie-break in `IDLE` when `ren` and `wen` are both asserted: serve the opposite of the 1-bit `last_served` flag. `last_served` updates on every finish.
- Abort: if the select of the in-progress access deasserts before its finish cycle, return to `IDLE` with no finish and no SRAM write. A read's early `mem_ce` is harmless.
- Outside a finish cycle, `rdata` shows the hold register.
- `mem_*` outputs are 0 in any cycle with no SRAM access.

## Timing
- Reset values: state `IDLE`, `cnt`=0, hold register 0, `last_served`=read (so the first tie serves the write), all outputs 0.
- Read latency: the request seen in cycle 0 finishes in cycle `RD_LATENCY`; the controller stalls the master through cycles 0..`RD_LATENCY`-1.
- Write latency: finish in cycle `WR_WAIT`.
- Finish pulses are exactly one cycle wide and never both high in the same cycle.
- Back-to-back: a select still asserted in the cycle after a finish is a new access, started from `IDLE` in that cycle.
- Reset asserted mid-access returns the block to `IDLE` immediately. No finish is issued and no partial write occurs unless `mem_we` was already high before reset.

## Test plan
- Word write then read, `RD_LATENCY`=1, `WR_WAIT`=0: write 0xDEADBEEF to word 5 → `write_finish` in cycle 0; read word 5 → `read_finish` in cycle 1 with `rdata`=0xDEADBEEF.
- Byte/halfword lanes: word preloaded with 0x11223344; byte write 0xAA at offset 2 → `mem_be`=4'b0100 and readback 0x11AA3344. Then halfword 0x5566 at offset 0 → readback 0x11AA5566.
- Simultaneous `ren`+`wen` held continuously from reset: completion order must be write, read, write, read; no starvation over 8 accesses.
- `RD_LATENCY`=3, `WR_WAIT`=2: finishes land exactly in cycles 3 and 2 respectively. Dropping `wen` in cycle 1 yields no `mem_we` and no `write_finish`.
- Out of range with `MEM_AW` wider than the array: write to word `DEPTH` finishes with `mem_ce`=0; read of word `DEPTH` finishes with `rdata`=0.
- Reset asserted in `READ` at cycle 1: all outputs 0 immediately; after release, a fresh read completes normally.
